input_data_store: RTL
=====================

Name: input_data_store

Overview:
- Word-addressed storage stage directly downstream of the UART number parser.
- Accepts single-cycle write strobes (address + 32-bit value) from the parser and tracks which addresses hold valid data and how many there are.
- Provides a registered read port for the compute/display FSMs.
- Provides a multi-cycle clear sequence the top FSM triggers before a new input session.

Parameters:
DEPTH, 256, number of storage words (1..2^AW)
AW, 8, address width
DW, 32, data width
MAX_VAL, 9, upper bound for stored values when range check is compiled in

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe from parser, one cycle per word
wr_addr  input  AW  write address
wr_data  input  DW  write data
clr_req  input  1  pulse: start clear sequence
rd_en  input  1  read request
rd_addr  input  AW  read address
rd_data  output  DW  read data, registered
rd_valid  output  1  pulse, rd_data valid this cycle
rd_hit  output  1  qualifies rd_data: 1 = address held valid data
word_count  output  AW+1  number of distinct valid addresses
full  output  1  word_count == DEPTH
busy  output  1  clear sequence in progress
wr_reject  output  1  pulse: write in previous cycle was dropped

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is asynchronous, active-low.

Reset (values apply immediately on rst_n low):
- rd_data = 0, rd_valid = 0, rd_hit = 0, word_count = 0, full = 0, busy = 0, wr_reject = 0.
- Valid bitmap all 0; FSM in IDLE.
- Memory array contents are not reset. The valid bitmap masks stale contents.

FSM states and transitions:
- IDLE -> CLEAR on clr_req. Clear counter set to 0, busy = 1 the next cycle.
- CLEAR, per cycle: writes 0 to mem[counter], clears valid[counter], increments counter.
- CLEAR -> IDLE after the write to address DEPTH-1. CLEAR lasts exactly DEPTH cycles; busy falls on the following cycle.
- word_count = 0 the cycle CLEAR is entered. Bitmap is cleared in bulk on entry; the address walk only zeroes data.
- clr_req while busy: ignored.

Write (IDLE only):
- wr_en with wr_addr < DEPTH stores wr_data at the next edge and sets valid[wr_addr].
- word_count increments only if valid[wr_addr] was 0. Overwriting an address keeps the count unchanged.
- wr_reject pulses 1 cycle after the strobe, and the write is dropped, when any of these hold:
  - wr_addr >= DEPTH
  - busy = 1
  - wr_en and clr_req in the same IDLE cycle (clear wins)
- full: combinational compare of word_count against DEPTH. Writes to new addresses are impossible once full, since all addresses are valid; overwrites are still accepted.

Read:
- Latency 1. rd_en at cycle N -> rd_valid = 1, rd_data, rd_hit at N+1.
- rd_hit = valid[rd_addr] sampled at N.
- rd_data = mem[rd_addr] if valid, else 0.
- Read and write to the same address in the same cycle: read-first, returns the old data and old valid bit.
- rd_addr >= DEPTH: rd_valid = 1, rd_hit = 0, rd_data = 0.
- Reads during CLEAR are allowed; they return 0 with rd_hit = 0.
- rd_data holds its value when rd_en = 0; rd_valid is a pulse.

Reset mid-CLEAR:
- Aborts immediately to reset values.
- Memory may hold partially zeroed data; it is masked by the valid bitmap.

Optional Feature:
STORE_RANGE_CHECK_EN
- Defined: a write with wr_data > MAX_VAL (unsigned) is dropped with wr_reject, and neither valid nor word_count changes.
- Undefined: any DW-bit value is stored; reject only for the address/busy/clear cases above.

Test Plan:
- Reset, write addrs 0,1,2 with 5,7,3; read addr 1 -> rd_valid next cycle, rd_data = 7, rd_hit = 1; word_count = 3.
- Write addr 4 value 2 twice, then value 8 -> word_count increments once; read returns 8.
- DEPTH = 4 build (AW = 3): fill addrs 0..3 -> full = 1; write addr 5 -> wr_reject pulse, word_count stays 4.
- clr_req with wr_en same cycle -> wr_reject = 1, busy high exactly DEPTH cycles, word_count = 0; read addr 0 -> rd_hit = 0, rd_data = 0.
- Same-cycle write 9 / read at addr 6 holding 4 -> read returns 4; next read returns 9. Assert rst_n mid-CLEAR -> busy = 0 immediately.
- With STORE_RANGE_CHECK_EN, MAX_VAL = 9: write value 10 -> wr_reject = 1, word_count unchanged; value 9 accepted.

Source files
------------

// File: rtl/input_data_store_if.sv
// Handshake/bus bundle between the number parser, the store and its readers.
// master drives write/read/clear requests; slave is the store itself.
interface input_data_store_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_req;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_hit;
    logic [AW:0]   word_count;
    logic          full;
    logic          busy;
    logic          wr_reject;

    modport master (
        output wr_en, wr_addr, wr_data, clr_req, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_hit, word_count, full, busy,
        wr_reject
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr_req, rd_en, rd_addr,
        output rd_data, rd_valid, rd_hit, word_count, full, busy,
        wr_reject
    );
endinterface

// File: rtl/input_data_store.sv
// Word store with valid bitmap, registered read port and DEPTH-cycle clear walk.
// Define STORE_RANGE_CHECK_EN to drop writes whose value exceeds MAX_VAL.
module input_data_store #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int MAX_VAL = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input_data_store_if.slave   bus
);
    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);
`ifdef STORE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW:0]      count_q;
    logic [DW-1:0]    rd_data_q;
    logic             rd_valid_q;
    logic             rd_hit_q;
    logic             wr_reject_q;

    logic          wr_in_range, rd_in_range, range_ok;
    logic          wr_ok, clr_start, rd_hit_d;
    logic [IW-1:0] widx, ridx;

    assign widx        = bus.wr_addr[IW-1:0];
    assign ridx        = bus.rd_addr[IW-1:0];
    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_W;
    assign range_ok    = !RANGE_EN || (bus.wr_data <= DW'(MAX_VAL));
    assign rd_hit_d    = rd_in_range && valid_q[ridx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clear request outranks a write strobe in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_start = 1'b0;
        wr_ok     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    clr_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = CLEAR;
                end else begin
                    wr_ok = bus.wr_en && wr_in_range && range_ok;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            count_q     <= '0;
            wr_reject_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_reject_q <= bus.wr_en && !wr_ok;
            if (clr_start) begin
                valid_q <= '0;
                count_q <= '0;
            end else if (wr_ok) begin
                valid_q[widx] <= 1'b1;
                if (!valid_q[widx]) count_q <= count_q + 1'b1;
            end
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_hit_q  <= rd_hit_d;
                rd_data_q <= rd_hit_d ? mem[ridx] : '0;
            end
        end
    end

    // Storage is not reset; stale words stay hidden behind valid_q.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) mem[cnt_q] <= '0;
        else if (wr_ok)       mem[widx]  <= bus.wr_data;
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_hit     = rd_hit_q;
    assign bus.word_count = count_q;
    assign bus.full       = (count_q == DEPTH_W);
    assign bus.busy       = (state_q == CLEAR);
    assign bus.wr_reject  = wr_reject_q;
endmodule
